// File: rtl/memory_stage_if.sv
// rtl/memory_stage_if.sv - Execution-to-memory stage bus: EX inputs, forwarding taps and MEM/WB results
interface memory_stage_if;

  // Pipeline control
  logic        Stall;
  logic        Flush;

  // Execution-stage results and control
  logic [31:0] ALUResult;
  logic [31:0] WriteData;
  logic [4:0]  RegDestAddress;
  logic        MemRead;
  logic        MemWrite;
  logic        MemtoReg;
  logic        RegWrite;
  logic [1:0]  MemSize;
  logic        MemSigned;

  // EX/MEM taps for the forwarding/hazard unit
  logic [4:0]  ExMem_RegDest;
  logic        ExMem_RegWrite;
  logic [31:0] ExMem_ALUResult;

  // MEM/WB results
  logic [31:0] MemReadData_Out;
  logic [31:0] ALUResult_Out;
  logic [4:0]  RegDestAddress_Out;
  logic        RegWrite_Out;
  logic        MemtoReg_Out;
  logic        MisalignedFault;

  // Upstream side: drives Execution results, observes the stage outputs
  modport master (
    output Stall, Flush,
    output ALUResult, WriteData, RegDestAddress,
    output MemRead, MemWrite, MemtoReg, RegWrite, MemSize, MemSigned,
    input  ExMem_RegDest, ExMem_RegWrite, ExMem_ALUResult,
    input  MemReadData_Out, ALUResult_Out, RegDestAddress_Out,
    input  RegWrite_Out, MemtoReg_Out, MisalignedFault
  );

  // Memory stage side
  modport slave (
    input  Stall, Flush,
    input  ALUResult, WriteData, RegDestAddress,
    input  MemRead, MemWrite, MemtoReg, RegWrite, MemSize, MemSigned,
    output ExMem_RegDest, ExMem_RegWrite, ExMem_ALUResult,
    output MemReadData_Out, ALUResult_Out, RegDestAddress_Out,
    output RegWrite_Out, MemtoReg_Out, MisalignedFault
  );

endinterface

// File: rtl/memory_stage.sv
// rtl/memory_stage.sv - MIPS MEM stage: EX/MEM register, word-organised data RAM, MEM/WB register
module memory_stage #(
  parameter int ADDR_W = 10
) (
  input logic           Clk,
  input logic           Rst,
  memory_stage_if.slave bus
);

  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;
  localparam int         DEPTH   = 2 ** ADDR_W;

  // EX/MEM register fields
  logic [31:0] ex_alu;
  logic [31:0] ex_wdata;
  logic [4:0]  ex_rd;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic        ex_mem_to_reg;
  logic        ex_reg_write;
  logic [1:0]  ex_size;
  logic        ex_signed;

  // MEM/WB register fields
  logic [31:0] wb_data;
  logic [31:0] wb_alu;
  logic [4:0]  wb_rd;
  logic        wb_reg_write;
  logic        wb_mem_to_reg;

  logic        fault;

  // Data RAM; contents survive reset
  logic [31:0] ram [0:DEPTH-1];

  // Access decode for the op sitting in EX/MEM
  logic              advance;
  logic              is_half;
  logic              is_byte;
  logic              is_word;
  logic              misaligned;
  logic [ADDR_W-1:0] word_idx;
  logic [1:0]        byte_off;
  logic [3:0]        lane_en;
  logic [31:0]       lane_data;
  logic              ram_we;
  logic [31:0]       rd_word;
  logic [31:0]       rd_shifted;
  logic [31:0]       load_ext;
  logic [31:0]       load_data;
  logic              reg_write_eff;

  // Flush overrides Stall, so the pipe moves whenever either allows it
  assign advance  = bus.Flush | ~bus.Stall;

  assign is_half  = (ex_size == SZ_HALF);
  assign is_byte  = (ex_size == SZ_BYTE);
  assign is_word  = ~is_half & ~is_byte;   // 00 and the unused 11 both mean word
  assign word_idx = ex_alu[ADDR_W+1:2];    // upper address bits ignored: wraps modulo RAM size
  assign byte_off = ex_alu[1:0];

  assign misaligned = (ex_mem_read | ex_mem_write) &
                      ((is_word & (byte_off != 2'b00)) | (is_half & byte_off[0]));

  // A faulting op must not update the register file
  assign reg_write_eff = ex_reg_write & ~misaligned;

  // Stores only land on an edge that advances the pipe and never when misaligned
  assign ram_we = advance & ex_mem_write & ~misaligned;

  // Byte-lane enables and replicated store data for the addressed lanes
  always_comb begin
    lane_en   = 4'b0000;
    lane_data = ex_wdata;
    if (is_byte) begin
      lane_en   = 4'b0001 << byte_off;
      lane_data = {4{ex_wdata[7:0]}};
    end else if (is_half) begin
      lane_en   = byte_off[1] ? 4'b1100 : 4'b0011;
      lane_data = {2{ex_wdata[15:0]}};
    end else begin
      lane_en   = 4'b1111;
      lane_data = ex_wdata;
    end
  end

  // RAM write port: only enabled lanes change, the rest are preserved
  always_ff @(posedge Clk) begin
    if (ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (lane_en[i]) begin
          ram[word_idx][8*i +: 8] <= lane_data[8*i +: 8];
        end
      end
    end
  end

  // Asynchronous read of the addressed word
  assign rd_word    = ram[word_idx];
  assign rd_shifted = rd_word >> {byte_off, 3'b000};

  // Right-justify the selected lane and extend it; word loads ignore MemSigned
  always_comb begin
    load_ext = rd_word;
    if (is_byte) begin
      load_ext = {{24{ex_signed & rd_shifted[7]}}, rd_shifted[7:0]};
    end else if (is_half) begin
      load_ext = {{16{ex_signed & rd_shifted[15]}}, rd_shifted[15:0]};
    end
  end

  // Only a clean, aligned, load-only op returns memory data
  assign load_data = (ex_mem_read & ~ex_mem_write & ~misaligned) ? load_ext : 32'd0;

  // EX/MEM register: flush injects a bubble, stall holds
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      ex_alu        <= 32'd0;
      ex_wdata      <= 32'd0;
      ex_rd         <= 5'd0;
      ex_mem_read   <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_mem_to_reg <= 1'b0;
      ex_reg_write  <= 1'b0;
      ex_size       <= 2'b00;
      ex_signed     <= 1'b0;
    end else if (advance) begin
      ex_alu        <= bus.ALUResult;
      ex_wdata      <= bus.WriteData;
      ex_size       <= bus.MemSize;
      ex_signed     <= bus.MemSigned;
      if (bus.Flush) begin
        ex_rd         <= 5'd0;
        ex_mem_read   <= 1'b0;
        ex_mem_write  <= 1'b0;
        ex_mem_to_reg <= 1'b0;
        ex_reg_write  <= 1'b0;
      end else begin
        ex_rd         <= bus.RegDestAddress;
        ex_mem_read   <= bus.MemRead;
        ex_mem_write  <= bus.MemWrite;
        ex_mem_to_reg <= bus.MemtoReg;
        ex_reg_write  <= bus.RegWrite;
      end
    end
  end

  // MEM/WB register: advances from the current EX/MEM contents
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      wb_data       <= 32'd0;
      wb_alu        <= 32'd0;
      wb_rd         <= 5'd0;
      wb_reg_write  <= 1'b0;
      wb_mem_to_reg <= 1'b0;
    end else if (advance) begin
      wb_data       <= load_data;
      wb_alu        <= ex_alu;
      wb_rd         <= ex_rd;
      wb_reg_write  <= reg_write_eff;
      wb_mem_to_reg <= ex_mem_to_reg;
    end
  end

  // Sticky misalignment flag, set only on an advancing edge
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      fault <= 1'b0;
    end else if (advance && misaligned) begin
      fault <= 1'b1;
    end
  end

  assign bus.ExMem_RegDest      = ex_rd;
  assign bus.ExMem_RegWrite     = reg_write_eff;
  assign bus.ExMem_ALUResult    = ex_alu;
  assign bus.MemReadData_Out    = wb_data;
  assign bus.ALUResult_Out      = wb_alu;
  assign bus.RegDestAddress_Out = wb_rd;
  assign bus.RegWrite_Out       = wb_reg_write;
  assign bus.MemtoReg_Out       = wb_mem_to_reg;
  assign bus.MisalignedFault    = fault;

endmodule

// File: tb/tb_memory_stage.sv
// tb/tb_memory_stage.sv - randomized bench for memory_stage against a byte-array pipeline model
module tb_memory_stage;

  typedef struct {
    logic [31:0] alu;
    logic [31:0] wd;
    logic [4:0]  rd;
    logic        mr;
    logic        mw;
    logic        m2r;
    logic        rw;
    logic [1:0]  sz;
    logic        sg;
  } op_t;

  logic Clk = 1'b0;
  logic Rst;

  memory_stage_if bus();

  memory_stage #(.ADDR_W(10)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  always #5 Clk = ~Clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: byte-addressed memory of 4 KiB plus the two stages
  logic [7:0]  mb [0:4095];
  op_t         m_ex;
  logic [31:0] m_wb_data;
  logic [31:0] m_wb_alu;
  logic [4:0]  m_wb_rd;
  logic        m_wb_rw;
  logic        m_wb_m2r;
  logic        m_fault;
  logic [31:0] init_words [0:63];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic op_t mk(input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] rd,
                             input logic mr, input logic mw, input logic m2r, input logic rw,
                             input logic [1:0] sz, input logic sg);
    op_t o;
    o.alu = alu; o.wd = wd; o.rd = rd; o.mr = mr; o.mw = mw;
    o.m2r = m2r; o.rw = rw; o.sz = sz; o.sg = sg;
    return o;
  endfunction

  function automatic int width_f(input logic [1:0] sz);
    if (sz == 2'd1) return 2;
    if (sz == 2'd2) return 1;
    return 4;
  endfunction

  function automatic logic misal_f(input op_t o);
    int a;
    int w;
    a = int'(o.alu & 32'hFFF);
    w = width_f(o.sz);
    return (o.mr || o.mw) && (a % w != 0);
  endfunction

  task automatic model_reset();
    m_ex      = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    m_wb_data = 0;
    m_wb_alu  = 0;
    m_wb_rd   = 0;
    m_wb_rw   = 0;
    m_wb_m2r  = 0;
    m_fault   = 0;
  endtask

  task automatic model_edge(input op_t o, input logic st, input logic fl);
    int a;
    int w;
    logic [31:0] v;
    logic mis;
    if (fl || !st) begin
      mis = misal_f(m_ex);
      w   = width_f(m_ex.sz);
      a   = int'(m_ex.alu & 32'hFFF);
      if (m_ex.mw && !mis)
        for (int i = 0; i < w; i++) mb[a + i] = 8'(m_ex.wd >> (8 * i));
      v = 0;
      if (m_ex.mr && !m_ex.mw && !mis) begin
        for (int i = 0; i < w; i++) v = v | (32'(mb[a + i]) << (8 * i));
        if (m_ex.sg && w == 1 && v[7])  v = v | 32'hFFFF_FF00;
        if (m_ex.sg && w == 2 && v[15]) v = v | 32'hFFFF_0000;
      end
      m_wb_data = v;
      m_wb_alu  = m_ex.alu;
      m_wb_rd   = m_ex.rd;
      m_wb_rw   = m_ex.rw && !mis;
      m_wb_m2r  = m_ex.m2r;
      if (mis) m_fault = 1'b1;
      m_ex = o;
      if (fl) begin
        m_ex.rd = 0; m_ex.mr = 0; m_ex.mw = 0; m_ex.m2r = 0; m_ex.rw = 0;
      end
    end
  endtask

  task automatic compare_all();
    check("exmem_rd",  32'(bus.ExMem_RegDest),      32'(m_ex.rd));
    check("exmem_rw",  32'(bus.ExMem_RegWrite),     32'(m_ex.rw && !misal_f(m_ex)));
    check("exmem_alu", bus.ExMem_ALUResult,         m_ex.alu);
    check("wb_data",   bus.MemReadData_Out,         m_wb_data);
    check("wb_alu",    bus.ALUResult_Out,           m_wb_alu);
    check("wb_rd",     32'(bus.RegDestAddress_Out), 32'(m_wb_rd));
    check("wb_rw",     32'(bus.RegWrite_Out),       32'(m_wb_rw));
    check("wb_m2r",    32'(bus.MemtoReg_Out),       32'(m_wb_m2r));
    check("fault",     32'(bus.MisalignedFault),    32'(m_fault));
  endtask

  // Present one op, clock one edge, update the model, compare everything
  task automatic drive(input op_t o, input logic st, input logic fl);
    bus.ALUResult      = o.alu;
    bus.WriteData      = o.wd;
    bus.RegDestAddress = o.rd;
    bus.MemRead        = o.mr;
    bus.MemWrite       = o.mw;
    bus.MemtoReg       = o.m2r;
    bus.RegWrite       = o.rw;
    bus.MemSize        = o.sz;
    bus.MemSigned      = o.sg;
    bus.Stall          = st;
    bus.Flush          = fl;
    @(posedge Clk);
    model_edge(o, st, fl);
    #1;
    compare_all();
  endtask

  // Asynchronous reset pulse between edges; outputs must clear immediately
  task automatic reset_pulse();
    #2 Rst = 1'b0;
    model_reset();
    #1;
    compare_all();
    @(posedge Clk);
    #1 Rst = 1'b1;
  endtask

  function automatic op_t rand_op();
    op_t o;
    int kind;
    int w;
    logic [31:0] low;
    logic [31:0] tmp;
    kind = $urandom_range(0, 9);
    o = mk(0, $urandom, 5'($urandom_range(0, 31)), 0, 0, 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    o.mr = (kind <= 3) || (kind == 7);
    o.mw = (kind >= 4 && kind <= 7);
    w    = width_f(o.sz);
    low  = 32'($urandom_range(0, 255));
    if ($urandom_range(0, 3) != 0) low = low & ~32'(w - 1);
    o.alu = low;
    if ($urandom_range(0, 3) == 0) begin
      tmp   = $urandom;
      o.alu = (tmp & 32'hFFFF_F000) | low;
    end
    return o;
  endfunction

  op_t nop;

  initial begin
    nop = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4096; i++) mb[i] = 8'h00;
    bus.ALUResult = 0; bus.WriteData = 0; bus.RegDestAddress = 0;
    bus.MemRead = 0; bus.MemWrite = 0; bus.MemtoReg = 0; bus.RegWrite = 0;
    bus.MemSize = 0; bus.MemSigned = 0; bus.Stall = 0; bus.Flush = 0;

    // Reset state
    Rst = 1'b0;
    model_reset();
    @(posedge Clk);
    @(posedge Clk);
    #1;
    compare_all();
    Rst = 1'b1;

    // Fill words 0..63 with known data
    for (int i = 0; i < 64; i++) begin
      init_words[i] = $urandom;
      drive(mk(32'(i * 4), init_words[i], 0, 0, 1, 0, 0, 0, 0), 0, 0);
    end

    // Store word then load word
    drive(mk(32'h10, 32'hDEAD_BEEF, 0, 0, 1, 0, 0, 0, 0), 0, 0);
    drive(mk(32'h10, 0, 5, 1, 0, 1, 1, 0, 0), 0, 0);
    drive(nop, 0, 0);
    check("tp_ldw_data", bus.MemReadData_Out, 32'hDEAD_BEEF);
    check("tp_ldw_rd",   32'(bus.RegDestAddress_Out), 32'd5);
    check("tp_ldw_rw",   32'(bus.RegWrite_Out), 32'd1);
    check("tp_ldw_m2r",  32'(bus.MemtoReg_Out), 32'd1);

    // Byte store and mixed-width loads
    drive(mk(32'h12, 32'h0000_007F, 0, 0, 1, 0, 0, 2, 0), 0, 0);
    drive(mk(32'h13, 0, 6, 1, 0, 1, 1, 2, 1), 0, 0);
    drive(mk(32'h12, 0, 6, 1, 0, 1, 1, 1, 0), 0, 0);
    check("tp_ldb_signed", bus.MemReadData_Out, 32'hFFFF_FFDE);
    drive(mk(32'h10, 0, 6, 1, 0, 1, 1, 0, 0), 0, 0);
    check("tp_ldh_unsigned", bus.MemReadData_Out, 32'h0000_DE7F);
    drive(nop, 0, 0);
    check("tp_ldw_merged", bus.MemReadData_Out, 32'hDE7F_BEEF);

    // Misaligned word load
    drive(mk(32'h11, 0, 7, 1, 0, 1, 1, 0, 0), 0, 0);
    check("tp_mis_exmem_rw", 32'(bus.ExMem_RegWrite), 32'd0);
    drive(nop, 0, 0);
    check("tp_mis_data",  bus.MemReadData_Out, 32'd0);
    check("tp_mis_rw",    32'(bus.RegWrite_Out), 32'd0);
    check("tp_mis_fault", 32'(bus.MisalignedFault), 32'd1);
    drive(mk(32'h10, 0, 7, 1, 0, 1, 1, 0, 0), 0, 0);
    drive(nop, 0, 0);
    check("tp_fault_sticky", 32'(bus.MisalignedFault), 32'd1);

    // Store held under stall for three cycles, then a load of the same word
    drive(mk(32'h20, 32'h1, 0, 0, 1, 0, 0, 0, 0), 0, 0);
    for (int i = 0; i < 3; i++) drive(mk(32'h24, 32'h99, 9, 1, 1, 1, 1, 0, 0), 1, 0);
    drive(mk(32'h20, 0, 8, 1, 0, 1, 1, 0, 0), 0, 0);
    drive(nop, 0, 0);
    check("tp_stall_store", bus.MemReadData_Out, 32'h1);

    // Flushed store never reaches RAM
    drive(mk(32'h30, 32'hAA, 3, 0, 1, 1, 1, 0, 0), 0, 1);
    drive(nop, 0, 0);
    check("tp_flush_rw",  32'(bus.RegWrite_Out), 32'd0);
    check("tp_flush_m2r", 32'(bus.MemtoReg_Out), 32'd0);
    drive(mk(32'h30, 0, 4, 1, 0, 1, 1, 0, 0), 0, 0);
    drive(nop, 0, 0);
    check("tp_flush_ram", bus.MemReadData_Out, init_words[12]);

    // Aliased address
    drive(mk(32'h1010, 0, 2, 1, 0, 1, 1, 0, 0), 0, 0);
    drive(nop, 0, 0);
    check("tp_alias", bus.MemReadData_Out, 32'hDE7F_BEEF);

    // Reset while a store sits in EX/MEM
    drive(mk(32'h40, 32'hCAFE_F00D, 1, 0, 1, 0, 1, 0, 0), 0, 0);
    reset_pulse();
    check("tp_rst_fault", 32'(bus.MisalignedFault), 32'd0);
    drive(mk(32'h40, 0, 1, 1, 0, 1, 1, 0, 0), 0, 0);
    drive(nop, 0, 0);
    check("tp_rst_nostore", bus.MemReadData_Out, init_words[16]);

    // Randomized traffic with occasional stall, flush and reset
    for (int n = 0; n < 800; n++) begin
      if (n == 400) reset_pulse();
      drive(rand_op(), 1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 9) == 0));
    end
    drive(nop, 0, 0);
    drive(nop, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
